// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit that owns the architectural HI/LO registers.
// The result is computed when an operation issues and is committed after a fixed busy period.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in1E,
  input  logic [31:0] in2E,
  input  logic [3:0]  mduOpE,
  output logic        busyE,
  output logic [31:0] mduOutE
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        hi_reg;
  logic [31:0]        lo_reg;
  logic [31:0]        hi_next_reg;
  logic [31:0]        lo_next_reg;
  logic               commit_reg;

  logic               is_mult;
  logic               is_div;
  logic               is_signed;
  logic               issue;
  logic               finish;
  logic               mthi_we;
  logic               mtlo_we;

  assign is_mult   = (mduOpE == OP_MULT) || (mduOpE == OP_MULTU);
  assign is_div    = (mduOpE == OP_DIV)  || (mduOpE == OP_DIVU);
  assign is_signed = (mduOpE == OP_MULT) || (mduOpE == OP_DIV);

  // ---------------------------------------------------------------- multiply
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign mul_a   = {{32{is_signed & in1E[31]}}, in1E};
  assign mul_b   = {{32{is_signed & in2E[31]}}, in2E};
  assign product = mul_a * mul_b;

  // ---------------------------------------------------------------- divide
  // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot_out;
  logic [31:0] rem_out;
  logic        div_zero;

  assign a_neg    = is_signed & in1E[31];
  assign b_neg    = is_signed & in2E[31];
  assign a_mag    = a_neg ? (32'd0 - in1E) : in1E;
  assign b_mag    = b_neg ? (32'd0 - in2E) : in2E;
  assign div_zero = (in2E == 32'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_div_stage
      logic [31:0] rem_in;
      logic [31:0] rem_res;
      logic [32:0] shifted;
      logic [33:0] trial;

      if (gi == 0) begin : g_first
        assign rem_in = 32'd0;
      end else begin : g_rest
        assign rem_in = g_div_stage[gi-1].rem_res;
      end

      assign shifted             = {rem_in, a_mag[31-gi]};
      assign trial               = {1'b0, shifted} - {2'b00, b_mag};
      assign quot_mag[31-gi]     = ~trial[33];
      assign rem_res             = trial[33] ? shifted[31:0] : trial[31:0];
    end
  endgenerate

  assign rem_mag  = g_div_stage[31].rem_res;
  assign quot_out = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
  assign rem_out  = a_neg ? (32'd0 - rem_mag) : rem_mag;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (issue)  state_next = BUSY;
      BUSY:    if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every MD op seen while busy is dropped, so all write enables are gated by IDLE.
  always_comb begin
    busyE   = (state_reg == BUSY);
    issue   = (state_reg == IDLE) && (is_mult || is_div);
    finish  = (state_reg == BUSY) && (count_reg == CNT_W'(1));
    mthi_we = (state_reg == IDLE) && (mduOpE == OP_MTHI);
    mtlo_we = (state_reg == IDLE) && (mduOpE == OP_MTLO);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      hi_next_reg <= 32'd0;
      lo_next_reg <= 32'd0;
      commit_reg  <= 1'b0;
      count_reg   <= '0;
    end else begin
      if (issue) begin
        hi_next_reg <= is_mult ? product[63:32] : rem_out;
        lo_next_reg <= is_mult ? product[31:0]  : quot_out;
        commit_reg  <= is_mult || !div_zero;
        count_reg   <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (busyE) begin
        count_reg <= count_reg - CNT_W'(1);
      end

      if (finish && commit_reg) begin
        hi_reg <= hi_next_reg;
        lo_reg <= lo_next_reg;
      end
      if (mthi_we) hi_reg <= in1E;
      if (mtlo_we) lo_reg <= in1E;
    end
  end

  always_comb begin
    mduOutE = 32'd0;
    case (mduOpE)
      OP_MFHI: mduOutE = hi_reg;
      OP_MFLO: mduOutE = lo_reg;
      default: mduOutE = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_e.sv
// Bench for mdu_e: a reference model of HI/LO and the busy window checked every cycle,
// plus directed operations with hand-computed literal results.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in1E;
  logic [31:0] in2E;
  logic [3:0]  mduOpE;
  logic        busyE;
  logic [31:0] mduOutE;

  int compared   = 0;
  int mismatched = 0;
  logic checking = 1'b0;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .in1E(in1E), .in2E(in2E),
    .mduOpE(mduOpE), .busyE(busyE), .mduOutE(mduOutE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {valid, hi, lo} using plain wide arithmetic.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint q;
    longint r;
    logic [63:0] p;
    ref_op = '0;
    case (op)
      4'd1: begin p = 64'(sa * sb); ref_op = {1'b1, p}; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; ref_op = {1'b1, p}; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; ref_op = {1'b1, r[31:0], q[31:0]}; end
      4'd4: if (b != 0) begin q = ua / ub; r = ua % ub; ref_op = {1'b1, r[31:0], q[31:0]}; end
      default: ref_op = '0;
    endcase
  endfunction

  // Reference model: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  logic        m_pv;
  int          m_left;
  logic [64:0] m_res;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_left <= 0; m_pv <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pv) begin
        m_hi <= m_ph;
        m_lo <= m_pl;
      end
    end else begin
      if (mduOpE >= 4'd1 && mduOpE <= 4'd4) begin
        m_res   = ref_op(mduOpE, in1E, in2E);
        m_pv   <= m_res[64];
        m_ph   <= m_res[63:32];
        m_pl   <= m_res[31:0];
        m_left <= (mduOpE <= 4'd2) ? 5 : 10;
      end else if (mduOpE == 4'd7) begin
        m_hi <= in1E;
      end else if (mduOpE == 4'd8) begin
        m_lo <= in1E;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("model_busy", {31'd0, busyE}, {31'd0, (m_left > 0)});
      check("model_out", mduOutE,
            (mduOpE == 4'd5) ? m_hi : (mduOpE == 4'd6) ? m_lo : 32'd0);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mduOpE = op; in1E = a; in2E = b;
    if (op != 4'd0) $display("op=%0d in1=%h in2=%h busy=%0b", op, a, b, busyE);
    @(posedge clk); #1;
  endtask

  task automatic read_lit(input logic [3:0] op, input string name, input logic [31:0] exp);
    mduOpE = op; in1E = $urandom; in2E = $urandom;
    #2;
    $display("read %s op=%0d out=%h", name, op, mduOutE);
    check(name, mduOutE, exp);
    @(posedge clk); #1;
  endtask

  // Counts remaining busy cycles while scrambling operands to prove operand capture.
  task automatic wait_busy(input string name, input int already, input int exp);
    int n = 0;
    while (busyE && n < 50) begin
      mduOpE = 4'd0; in1E = $urandom; in2E = $urandom;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) $display("FAIL %s: busy never fell within 50 cycles", name);
    check(name, 32'(already + n), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; mduOpE = 0; in1E = 0; in2E = 0;
    drive(4'd0, 0, 0);
    drive(4'd0, 0, 0);
    reset = 1'b0;
    checking = 1'b1;

    // 1: reset state
    check("reset_busy", {31'd0, busyE}, 32'd0);
    read_lit(4'd5, "reset_hi", 32'h0);
    read_lit(4'd6, "reset_lo", 32'h0);

    // 2: multiply
    drive(4'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_busy("mult_busy_len", 0, 5);
    read_lit(4'd5, "mult_hi", 32'hFFFFFFFF);
    read_lit(4'd6, "mult_lo", 32'hFFFFFFFA);
    drive(4'd2, 32'hFFFFFFFE, 32'h00000003);
    wait_busy("multu_busy_len", 0, 5);
    read_lit(4'd5, "multu_hi", 32'h00000002);
    read_lit(4'd6, "multu_lo", 32'hFFFFFFFA);

    // 3: divide
    drive(4'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_busy("div_busy_len", 0, 10);
    read_lit(4'd6, "div_lo", 32'hFFFFFFFD);
    read_lit(4'd5, "div_hi", 32'hFFFFFFFF);
    drive(4'd4, 32'd7, 32'd2);
    wait_busy("divu_busy_len", 0, 10);
    read_lit(4'd6, "divu_lo", 32'd3);
    read_lit(4'd5, "divu_hi", 32'd1);
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_busy("divovf_busy_len", 0, 10);
    read_lit(4'd6, "divovf_lo", 32'h80000000);
    read_lit(4'd5, "divovf_hi", 32'h0);

    // 4: moves, then divide by zero keeps HI/LO
    drive(4'd7, 32'h12345678, 32'h0);
    drive(4'd8, 32'h9ABCDEF0, 32'h0);
    read_lit(4'hF, "undef_out", 32'h0);
    drive(4'd4, 32'd5, 32'd0);
    wait_busy("div0_busy_len", 0, 10);
    read_lit(4'd5, "div0_hi", 32'h12345678);
    read_lit(4'd6, "div0_lo", 32'h9ABCDEF0);

    // 5: ops while busy are ignored; reads still see the old value
    drive(4'd1, 32'h00012345, 32'h00100000);
    drive(4'd8, 32'h00000055, 32'h0);
    drive(4'd1, 32'd7, 32'd9);
    read_lit(4'd6, "busy_read_lo", 32'h9ABCDEF0);
    wait_busy("ignored_busy_len", 3, 5);
    read_lit(4'd5, "ignored_hi", 32'h00000012);
    read_lit(4'd6, "ignored_lo", 32'h34500000);

    // 6: reset mid-divide abandons the result
    drive(4'd3, 32'd100, 32'd7);
    drive(4'd0, 0, 0);
    drive(4'd0, 0, 0);
    drive(4'd0, 0, 0);
    reset = 1'b1;
    drive(4'd0, 0, 0);
    reset = 1'b0;
    check("abort_busy", {31'd0, busyE}, 32'd0);
    read_lit(4'd5, "abort_hi", 32'h0);
    read_lit(4'd6, "abort_lo", 32'h0);
    for (int i = 0; i < 12; i++) drive(4'd0, $urandom, $urandom);
    read_lit(4'd6, "abort_late_lo", 32'h0);
    read_lit(4'd5, "abort_late_hi", 32'h0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
